shift_arbiter: RTL

- Sequencer and arbiter that shares one 16-bit Shifter instance (SLL/SRA/ROR) between two requesters, e.g. the execute-stage ALU path and the load/store alignment path.
- Extends the shift amount to 5 bits: SLL/SRA amounts of 16-31 run as two passes through the 4-bit Shifter.
- Valid/ready handshake on each request port; one registered response port tagged with the requester ID.

---
 rtl/shift_arbiter_if.sv | 40 ++++
 rtl/shift_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - request/response bundle for the shared shifter arbiter
interface shift_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [AMT_W-1:0]  req0_shamt;
    logic [1:0]        req0_mode;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [AMT_W-1:0]  req1_shamt;
    logic [1:0]        req1_mode;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_mode,
        input  req1_valid, req1_data, req1_shamt, req1_mode,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_mode,
        output req1_valid, req1_data, req1_shamt, req1_mode,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
    );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sequencer sharing one 16-bit SLL/SRA/ROR shifter
module shift_arbiter #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_arbiter_if.slave  bus
);
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {IDLE, SHIFT1, SHIFT2, RESP} state_t;

    state_t            state_q, state_d;
    logic              ptr_q;
    logic [DATA_W-1:0] op_q, acc_q;
    logic [AMT_W-1:0]  amt_q;
    logic [1:0]        mode_q;
    logic              id_q;

    logic              rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              any_valid, grant_id, accept;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_shamt;
    logic [1:0]        sel_mode;

    logic [DATA_W-1:0] sh_in, sh_out;
    logic [3:0]        sh_amt;
    logic [AMT_W-1:0]  amt_rem;
    logic [2*DATA_W-1:0] rot_dbl;
    logic              two_pass;

    // Grant selection: pointer owner wins a tie, otherwise the sole requester
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant_id  = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
        accept    = (state_q == IDLE) && any_valid;
        sel_data  = grant_id ? bus.req1_data  : bus.req0_data;
        sel_shamt = grant_id ? bus.req1_shamt : bus.req0_shamt;
        sel_mode  = grant_id ? bus.req1_mode  : bus.req0_mode;
    end

    // Shifter operand/amount come only from latched state; amounts above 15 split over two passes
    always_comb begin
        two_pass = (mode_q != MODE_ROR) && amt_q[AMT_W-1];
        amt_rem  = amt_q - AMT_W'(15);
        sh_in    = op_q;
        sh_amt   = amt_q[3:0];
        if (state_q == SHIFT2) begin
            sh_in  = acc_q;
            sh_amt = amt_rem[AMT_W-1] ? 4'hF : amt_rem[3:0];
        end else if (two_pass) begin
            sh_amt = 4'hF;
        end
    end

    // The shared 16-bit shifter
    always_comb begin
        rot_dbl = {sh_in, sh_in} >> sh_amt;
        case (mode_q)
            MODE_SLL: sh_out = sh_in << sh_amt;
            MODE_SRA: sh_out = DATA_W'($signed(sh_in) >>> sh_amt);
            MODE_ROR: sh_out = rot_dbl[DATA_W-1:0];
            default:  sh_out = sh_in;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = (sel_mode == 2'b11) ? RESP : SHIFT1;
            SHIFT1:  state_d = two_pass ? SHIFT2 : RESP;
            SHIFT2:  state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch the granted request, rotate the pointer, keep the first-pass result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= 1'b0;
            op_q   <= '0;
            acc_q  <= '0;
            amt_q  <= '0;
            mode_q <= MODE_SLL;
            id_q   <= 1'b0;
        end else if (accept) begin
            ptr_q  <= ~grant_id;
            op_q   <= sel_data;
            amt_q  <= sel_shamt;
            mode_q <= sel_mode;
            id_q   <= grant_id;
        end else if (state_q == SHIFT1) begin
            acc_q  <= sh_out;
        end
    end

    // Response register: loaded on entry to RESP, held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (state_q != RESP && state_d == RESP) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (state_q == IDLE) ? sel_data : sh_out;
            rsp_id_q    <= (state_q == IDLE) ? grant_id : id_q;
            rsp_err_q   <= (state_q == IDLE);
        end else if (state_q == RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept &&  grant_id;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
